rle_expand_ctrl: RTL and testbench

Sequencer between two FIFOStack instances in the RLE decompression path. Pops (count, symbol) byte pairs from the upstream compressed-stream FIFO and pushes each symbol count times into the downstream expanded-data FIFO. Drives the FIFOs' rd/wr strobes from their empty/full flags. Upstream FIFO data is first-word-fall-through: data_out is valid whenever not empty, and rd pops it.

---
 rtl/rle_pkg.sv | 14 +
 rtl/rle_expand_ctrl.sv | 95 +++++++++
 tb/tb_rle_expand_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared types and defaults for the RLE expansion sequencer.
package rle_pkg;

  localparam int RLE_DATA_W = 8;
  localparam int RLE_BCNT_W = 16;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and falls back to GET_CNT.
  typedef enum logic [1:0] {
    GET_CNT = 2'd0,
    GET_SYM = 2'd1,
    EMIT    = 2'd2
  } rle_state_e;

endpackage

// File: rtl/rle_expand_ctrl.sv
// Pops (count, symbol) pairs from a FWFT FIFO and writes each symbol count times downstream.
// 2 cycles of pop overhead per pair, then 1 byte/cycle; stalls on out_full, waits on in_empty.
module rle_expand_ctrl
  import rle_pkg::*;
#(
  parameter int DATA_W = RLE_DATA_W,
  parameter int BCNT_W = RLE_BCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_empty,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rd,
  input  logic              out_full,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              run_done,
  output logic [BCNT_W-1:0] byte_count
);

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] run_cnt_q, run_cnt_d;
  logic [DATA_W-1:0] sym_q, sym_d;
  logic [BCNT_W-1:0] byte_count_q, byte_count_d;
  logic              run_done_q, run_done_d;

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    sym_d        = sym_q;
    byte_count_d = byte_count_q;
    run_done_d   = 1'b0;
    in_rd        = 1'b0;
    out_wr       = 1'b0;

    case (state_q)
      GET_CNT: begin
        if (en && !in_empty) begin
          in_rd     = 1'b1;
          run_cnt_d = in_data;
          state_d   = GET_SYM;
        end
      end
      GET_SYM: begin
        // Once the count is popped the pair is committed, so en is ignored here.
        if (!in_empty) begin
          in_rd   = 1'b1;
          sym_d   = in_data;
          state_d = (run_cnt_q == '0) ? GET_CNT : EMIT;
        end
      end
      EMIT: begin
        if (!out_full) begin
          out_wr       = 1'b1;
          run_cnt_d    = run_cnt_q - DATA_W'(1);
          byte_count_d = byte_count_q + BCNT_W'(1);
          if (run_cnt_q == DATA_W'(1)) begin
            state_d    = GET_CNT;
            run_done_d = 1'b1;
          end
        end
      end
      default: state_d = GET_CNT;
    endcase

    if (rst) begin
      in_rd  = 1'b0;
      out_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GET_CNT;
      run_cnt_q    <= '0;
      sym_q        <= '0;
      byte_count_q <= '0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      sym_q        <= sym_d;
      byte_count_q <= byte_count_d;
      run_done_q   <= run_done_d;
    end
  end

  assign out_data   = sym_q;
  assign busy       = (state_q != GET_CNT);
  assign run_done   = run_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rle_expand_ctrl.sv
// Bench for rle_expand_ctrl: both FIFOs modelled as queues, output stream checked against pair expansion.
module tb_rle_expand_ctrl;
  import rle_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, in_empty, out_full;
  logic [7:0]  in_data;
  logic        in_rd, out_wr, busy, run_done;
  logic [7:0]  out_data;
  logic [15:0] byte_count;

  rle_expand_ctrl #(.DATA_W(8), .BCNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_empty(in_empty), .in_data(in_data), .in_rd(in_rd),
    .out_full(out_full), .out_wr(out_wr), .out_data(out_data),
    .busy(busy), .run_done(run_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] up_q[$];
  logic [7:0] wr_q[$];
  int         wr_t[$];
  int         done_cnt, rd_cnt, proto_err, cyc;
  logic       force_full, hold_empty;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] sym;
    int         exp_writes;
    int         exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void refresh();
    in_empty = hold_empty || (up_q.size() == 0);
    in_data  = (up_q.size() != 0) ? up_q[0] : 8'h00;
    out_full = force_full;
  endfunction

  function automatic void clear_mon();
    wr_q.delete();
    wr_t.delete();
    done_cnt = 0;
    rd_cnt   = 0;
  endfunction

  // One clock: sample the DUT mid-cycle, then apply FIFO side effects after the edge.
  task automatic tick();
    logic rd, wr;
    logic [7:0] od;
    @(negedge clk);
    rd = in_rd; wr = out_wr; od = out_data;
    if (rd && in_empty) proto_err++;
    if (wr && out_full) proto_err++;
    if (run_done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd && !in_empty) begin
      void'(up_q.pop_front());
      rd_cnt++;
    end
    if (wr && !out_full) begin
      wr_q.push_back(od);
      wr_t.push_back(cyc);
    end
    refresh();
  endtask

  task automatic run_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (i > 1 && !busy && (up_q.size() == 0 || !en)) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tick();
    if (!ok) chk({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    up_q.delete();
    rst = 1'b0;
    refresh();
    clear_mon();
  endtask

  function automatic int count_not(input logic [7:0] sym);
    int bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== sym) bad++;
    return bad;
  endfunction

  initial begin
    vec_t       vecs[6];
    logic [15:0] bc0, bc_d;
    logic [7:0] exp_s[$];
    int         nz_pairs, mism, exp_total;

    proto_err = 0; cyc = 0;
    force_full = 1'b0; hold_empty = 1'b0;
    en = 1'b1; rst = 1'b1;
    up_q.push_back(8'd3); up_q.push_back(8'h41);
    refresh();
    clear_mon();

    // Reset state, with upstream data present: strobes must stay low while rst is high.
    @(negedge clk);
    chk("rst in_rd", {31'd0, in_rd}, 32'd0);
    chk("rst out_wr", {31'd0, out_wr}, 32'd0);
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst run_done", {31'd0, run_done}, 32'd0);
    chk("rst byte_count", {16'd0, byte_count}, 32'd0);
    chk("rst out_data", {24'd0, out_data}, 32'd0);
    do_reset();

    vecs[0] = '{cnt: 8'd3,   sym: 8'h41, exp_writes: 3,   exp_done: 1};
    vecs[1] = '{cnt: 8'd0,   sym: 8'h55, exp_writes: 0,   exp_done: 0};
    vecs[2] = '{cnt: 8'd2,   sym: 8'h10, exp_writes: 2,   exp_done: 1};
    vecs[3] = '{cnt: 8'd1,   sym: 8'hFF, exp_writes: 1,   exp_done: 1};
    vecs[4] = '{cnt: 8'd255, sym: 8'hC3, exp_writes: 255, exp_done: 1};
    vecs[5] = '{cnt: 8'd0,   sym: 8'h00, exp_writes: 0,   exp_done: 0};

    foreach (vecs[v]) begin
      clear_mon();
      bc0 = byte_count;
      up_q.push_back(vecs[v].cnt);
      up_q.push_back(vecs[v].sym);
      refresh();
      run_idle(400, $sformatf("vec%0d", v));
      bc_d = byte_count - bc0;
      chk($sformatf("vec%0d writes", v), wr_q.size(), vecs[v].exp_writes);
      chk($sformatf("vec%0d data", v), count_not(vecs[v].sym), 0);
      chk($sformatf("vec%0d run_done", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("vec%0d byte_count", v), {16'd0, bc_d}, vecs[v].exp_writes);
      chk($sformatf("vec%0d pops", v), rd_cnt, 2);
      chk($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
      if (vecs[v].exp_writes > 0)
        chk($sformatf("vec%0d back-to-back", v), wr_t[wr_t.size()-1] - wr_t[0], vecs[v].exp_writes - 1);
    end

    // Downstream full on the 2nd and 3rd EMIT cycles.
    do_reset();
    up_q.push_back(8'd4); up_q.push_back(8'h7E);
    refresh();
    tick(); tick(); tick();
    chk("stall pre writes", wr_q.size(), 1);
    force_full = 1'b1; refresh();
    #1;
    chk("stall out_wr", {31'd0, out_wr}, 32'd0);
    bc0 = byte_count;
    tick(); tick();
    chk("stall writes held", wr_q.size(), 1);
    chk("stall byte_count held", {16'd0, byte_count}, {16'd0, bc0});
    chk("stall busy", {31'd0, busy}, 32'd1);
    force_full = 1'b0; refresh();
    run_idle(50, "stall");
    chk("stall writes", wr_q.size(), 4);
    chk("stall data", count_not(8'h7E), 0);
    chk("stall run_done", done_cnt, 1);
    chk("stall byte_count", {16'd0, byte_count}, 32'd4);

    // Symbol arrives 5 cycles after the count.
    do_reset();
    up_q.push_back(8'd3);
    refresh();
    for (int i = 0; i < 6; i++) tick();
    chk("late sym pops", rd_cnt, 1);
    chk("late sym busy", {31'd0, busy}, 32'd1);
    chk("late sym writes", wr_q.size(), 0);
    up_q.push_back(8'h5A);
    refresh();
    run_idle(50, "late sym");
    chk("late sym total", wr_q.size(), 3);
    chk("late sym data", count_not(8'h5A), 0);
    chk("late sym run_done", done_cnt, 1);

    // Max run, en dropped mid-run; the next pair must wait for en.
    do_reset();
    up_q.push_back(8'd255); up_q.push_back(8'hAA);
    up_q.push_back(8'd1);   up_q.push_back(8'h01);
    refresh();
    for (int i = 0; i < 100 && wr_q.size() < 10; i++) tick();
    chk("max en-drop point", wr_q.size(), 10);
    en = 1'b0;
    run_idle(400, "max run");
    for (int i = 0; i < 5; i++) tick();
    chk("max writes", wr_q.size(), 255);
    chk("max data", count_not(8'hAA), 0);
    chk("max next pair held", up_q.size(), 2);
    chk("max busy", {31'd0, busy}, 32'd0);
    en = 1'b1;
    run_idle(50, "max resume");
    chk("max total writes", wr_q.size(), 256);
    chk("max last byte", {24'd0, wr_q[wr_q.size()-1]}, 32'h01);
    chk("max byte_count", {16'd0, byte_count}, 32'd256);
    chk("max run_done", done_cnt, 2);

    // Reset in the middle of a run.
    do_reset();
    up_q.push_back(8'd10); up_q.push_back(8'h33);
    refresh();
    for (int i = 0; i < 30 && wr_q.size() < 4; i++) tick();
    chk("mid-rst writes before", wr_q.size(), 4);
    rst = 1'b1;
    tick();
    chk("mid-rst out_wr", {31'd0, out_wr}, 32'd0);
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst byte_count", {16'd0, byte_count}, 32'd0);
    chk("mid-rst run_done", {31'd0, run_done}, 32'd0);
    chk("mid-rst no extra write", wr_q.size(), 4);
    up_q.delete();
    rst = 1'b0;
    clear_mon();
    up_q.push_back(8'd2); up_q.push_back(8'h99);
    refresh();
    run_idle(50, "post-rst");
    chk("post-rst writes", wr_q.size(), 2);
    chk("post-rst data", count_not(8'h99), 0);
    chk("post-rst run_done", done_cnt, 1);
    chk("post-rst byte_count", {16'd0, byte_count}, 32'd2);

    // Random pairs with random en, empty gaps and downstream backpressure.
    do_reset();
    exp_s.delete();
    nz_pairs = 0;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] c, s;
      c = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      s = 8'($urandom);
      up_q.push_back(c);
      up_q.push_back(s);
      if (c != 0) nz_pairs++;
      for (int k = 0; k < int'(c); k++) exp_s.push_back(s);
    end
    for (int i = 0; i < 4000 && (up_q.size() != 0 || busy); i++) begin
      force_full = ($urandom_range(0, 3) == 0);
      hold_empty = ($urandom_range(0, 4) == 0);
      en         = ($urandom_range(0, 4) != 0);
      refresh();
      tick();
    end
    force_full = 1'b0; hold_empty = 1'b0; en = 1'b1;
    refresh();
    run_idle(100, "random");
    exp_total = exp_s.size();
    chk("rand writes", wr_q.size(), exp_total);
    mism = 0;
    for (int i = 0; i < exp_total && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_s[i]) mism++;
    chk("rand stream", mism, 0);
    chk("rand run_done", done_cnt, nz_pairs);
    chk("rand byte_count", {16'd0, byte_count}, exp_total & 32'hFFFF);
    chk("rand drained", up_q.size(), 0);

    chk("protocol (pop on empty / write on full)", proto_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
